// File: rtl/dbg_frame_parser.sv
// Debug frame parser: RX bytes -> one register access per frame -> response bytes into TX.
// Optional checksum byte on requests and read responses when DBG_PARSER_CHECKSUM_EN is defined.
module dbg_frame_parser #(
  parameter int CLK_RATE       = 100*10**6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK_I,
  input  logic        RST_NI,
  output logic        RE_O,
  input  logic [7:0]  DREC_I,
  input  logic        RX_EMPTY_I,
  output logic        WE_O,
  output logic [7:0]  DSEND_O,
  input  logic        TX_READY_I,
  output logic [6:0]  REG_ADDR_O,
  output logic [31:0] REG_WDATA_O,
  output logic        REG_WE_O,
  output logic        REG_RE_O,
  input  logic [31:0] REG_RDATA_I,
  input  logic        REG_ACK_I,
  output logic        FRAME_ERR_O
);

  // Clock rate is informational; the empty block only documents the legal ranges.
  if (CLK_RATE <= 0 || TIMEOUT_CYCLES < 2) begin : g_param_range
  end

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef DBG_PARSER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd3;
`endif
  localparam logic [2:0] S_ACCESS = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [7:0] HEADER   = 8'h01;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  logic [2:0]    state;
  logic [TW-1:0] tcnt;
  logic [1:0]    idx;
  logic          wr;
  logic          nak;
  logic [2:0]    ridx;
  logic [31:0]   rdata_q;
  logic [7:0]    resp_byte;
  logic          resp_last;
  logic          rx_state;
  logic          counting;
  logic          timeout;
  logic          pop;

`ifdef DBG_PARSER_CHECKSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction
`endif

  always_comb begin
    rx_state = (state == S_IDLE) || (state == S_CMD) || (state == S_DATA);
`ifdef DBG_PARSER_CHECKSUM_EN
    if (state == S_CHK) rx_state = 1'b1;
`endif
  end

  assign pop      = rx_state & ~RX_EMPTY_I;
  assign RE_O     = pop;
  assign counting = (rx_state && (state != S_IDLE) && RX_EMPTY_I) || (state == S_ACCESS);
  // Fires one cycle early so the registered error pulse lands on the last counted cycle.
  assign timeout  = counting && (tcnt == T_LAST);

  always_comb begin
    resp_byte = ACK_BYTE;
    resp_last = 1'b1;
    if (nak) begin
      resp_byte = NAK_BYTE;
    end else if (!wr) begin
      resp_byte = rdata_q[8*ridx[1:0] +: 8];
`ifdef DBG_PARSER_CHECKSUM_EN
      if (ridx[2]) resp_byte = xor4(rdata_q);
      resp_last = (ridx == 3'd4);
`else
      resp_last = (ridx == 3'd3);
`endif
    end
  end

  assign WE_O    = (state == S_RESP) & TX_READY_I;
  assign DSEND_O = (state == S_RESP) ? resp_byte : 8'h00;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      idx         <= '0;
      wr          <= 1'b0;
      nak         <= 1'b0;
      ridx        <= '0;
      REG_ADDR_O  <= '0;
      REG_WDATA_O <= '0;
      REG_WE_O    <= 1'b0;
      REG_RE_O    <= 1'b0;
      FRAME_ERR_O <= 1'b0;
`ifdef DBG_PARSER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      FRAME_ERR_O <= 1'b0;
      if (pop) tcnt <= '0;
      else if (counting) tcnt <= tcnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (pop && DREC_I == HEADER) begin
            state <= S_CMD;
            tcnt  <= '0;
          end
        end
        S_CMD: begin
          if (timeout) begin
            state       <= S_IDLE;
            FRAME_ERR_O <= 1'b1;
            tcnt        <= '0;
          end else if (pop) begin
            REG_ADDR_O <= DREC_I[6:0];
            wr         <= DREC_I[7];
            nak        <= 1'b0;
            idx        <= '0;
            tcnt       <= '0;
`ifdef DBG_PARSER_CHECKSUM_EN
            csum       <= DREC_I;
            state      <= DREC_I[7] ? S_DATA : S_CHK;
`else
            if (DREC_I[7]) begin
              state <= S_DATA;
            end else begin
              state    <= S_ACCESS;
              REG_RE_O <= 1'b1;
            end
`endif
          end
        end
        S_DATA: begin
          if (timeout) begin
            state       <= S_IDLE;
            FRAME_ERR_O <= 1'b1;
            tcnt        <= '0;
          end else if (pop) begin
            REG_WDATA_O[8*idx +: 8] <= DREC_I;
            idx <= idx + 2'd1;
`ifdef DBG_PARSER_CHECKSUM_EN
            csum <= csum ^ DREC_I;
`endif
            if (idx == 2'd3) begin
              tcnt <= '0;
`ifdef DBG_PARSER_CHECKSUM_EN
              state <= S_CHK;
`else
              state    <= S_ACCESS;
              REG_WE_O <= 1'b1;
`endif
            end
          end
        end
`ifdef DBG_PARSER_CHECKSUM_EN
        S_CHK: begin
          if (timeout) begin
            state       <= S_IDLE;
            FRAME_ERR_O <= 1'b1;
            tcnt        <= '0;
          end else if (pop) begin
            tcnt <= '0;
            if (DREC_I == csum) begin
              state    <= S_ACCESS;
              REG_WE_O <= wr;
              REG_RE_O <= ~wr;
            end else begin
              state       <= S_RESP;
              nak         <= 1'b1;
              ridx        <= '0;
              FRAME_ERR_O <= 1'b1;
            end
          end
        end
`endif
        S_ACCESS: begin
          // A completed access wins over a timeout landing in the same cycle.
          if (REG_ACK_I) begin
            REG_WE_O <= 1'b0;
            REG_RE_O <= 1'b0;
            ridx     <= '0;
            state    <= S_RESP;
            tcnt     <= '0;
          end else if (timeout) begin
            REG_WE_O    <= 1'b0;
            REG_RE_O    <= 1'b0;
            nak         <= 1'b1;
            ridx        <= '0;
            FRAME_ERR_O <= 1'b1;
            state       <= S_RESP;
            tcnt        <= '0;
          end
        end
        S_RESP: begin
          if (TX_READY_I) begin
            ridx <= ridx + 3'd1;
            if (resp_last) begin
              state <= S_IDLE;
              tcnt  <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data is a pure datapath capture; the FSM decides whether it is ever sent.
  always_ff @(posedge CLK_I) begin
    if (state == S_ACCESS && REG_ACK_I) rdata_q <= REG_RDATA_I;
  end

endmodule

// File: tb/tb_dbg_frame_parser.sv
// Directed bench for dbg_frame_parser: RX/TX FIFO models and a register slave with programmable ack delay.
module tb_dbg_frame_parser;
  localparam int TO = 16;
`ifdef DBG_PARSER_CHECKSUM_EN
  localparam int RD_LEN = 5;
`else
  localparam int RD_LEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        re, we, reg_we, reg_re, frame_err;
  logic        rx_empty = 1'b1;
  logic        tx_ready = 1'b0;
  logic        reg_ack = 1'b0;
  logic [7:0]  drec = 8'h00;
  logic [7:0]  dsend;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = 32'h0;

  always #5 clk = ~clk;

  dbg_frame_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .RE_O(re), .DREC_I(drec), .RX_EMPTY_I(rx_empty),
    .WE_O(we), .DSEND_O(dsend), .TX_READY_I(tx_ready), .REG_ADDR_O(reg_addr),
    .REG_WDATA_O(reg_wdata), .REG_WE_O(reg_we), .REG_RE_O(reg_re),
    .REG_RDATA_I(reg_rdata), .REG_ACK_I(reg_ack), .FRAME_ERR_O(frame_err)
  );

  logic [7:0] rx_mem [0:255];
  logic [7:0] tx_mem [0:255];
  int rx_wr = 0, rx_rd = 0, tx_n = 0;
  int total = 0, bad = 0;
  int cyc = 0, pop_cyc = 0, we_viol = 0;
  int req_cnt = 0, ack_delay = 1000;
  int re_cycles = 0, we_cycles = 0, err_cnt = 0, err_cyc = 0;
  int req_rise_cyc = 0, ack_cyc = 0, we_rise_cyc = 0;
  logic prev_req = 1'b0, prev_we = 1'b0;
  logic [6:0]  rd_addr = 7'h0, wr_addr = 7'h0;
  logic [31:0] wr_data = 32'h0;

  // FIFO models act on the edge, exactly as the real FIFOs would
  always @(posedge clk) begin
    cyc++;
    if (re && rx_rd < rx_wr) begin
      pop_cyc = cyc;
      rx_rd++;
    end
    if (we) begin
      if (tx_n < 256) tx_mem[tx_n] = dsend;
      tx_n++;
      if (!tx_ready) we_viol++;
    end
    #1;
    rx_empty = (rx_rd >= rx_wr);
    drec = rx_empty ? 8'h00 : rx_mem[rx_rd];
  end

  always @(negedge clk) begin
    if (reg_re || reg_we) begin
      req_cnt++;
      if (!prev_req) req_rise_cyc = cyc;
      if (reg_re) begin re_cycles++; rd_addr = reg_addr; end
      if (reg_we) begin we_cycles++; wr_addr = reg_addr; wr_data = reg_wdata; end
    end else begin
      req_cnt = 0;
    end
    reg_ack = (req_cnt == ack_delay);
    if (reg_ack) ack_cyc = cyc;
    prev_req = reg_re || reg_we;
    if (we && !prev_we) we_rise_cyc = cyc;
    prev_we = we;
    if (frame_err) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tx_at(input int i);
    if (i < tx_n && i < 256) return {24'h0, tx_mem[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic send_read(input logic [6:0] a);
    push(8'h01);
    push({1'b0, a});
`ifdef DBG_PARSER_CHECKSUM_EN
    push({1'b0, a});
`endif
  endtask

  task automatic send_write(input logic [6:0] a, input logic [31:0] d);
    push(8'h01);
    push({1'b1, a});
    for (int i = 0; i < 4; i++) push(d[8*i +: 8]);
`ifdef DBG_PARSER_CHECKSUM_EN
    push({1'b1, a} ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
`endif
  endtask

  task automatic wait_tx(input int target, input int budget);
    for (int k = 0; k < budget && tx_n < target; k++) @(negedge clk);
  endtask

  task automatic check_read(input string tag, input int base, input logic [31:0] d);
    check({tag, "_len"}, tx_n - base, RD_LEN);
    for (int i = 0; i < 4; i++) check({tag, "_byte"}, tx_at(base + i), {24'h0, d[8*i +: 8]});
`ifdef DBG_PARSER_CHECKSUM_EN
    check({tag, "_csum"}, tx_at(base + 4), {24'h0, d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]});
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0, r0, w0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {12'h0, re, we, dsend, reg_addr, reg_we, reg_re, frame_err}, 32'h0);
    check("rst_wdata", reg_wdata, 32'h0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);

    // read with ack on the third request cycle
    reg_rdata = 32'hDEADBEEF; ack_delay = 3; base = tx_n; r0 = re_cycles;
    send_read(7'h05);
    wait_tx(base + RD_LEN, 100);
    check_read("rd", base, 32'hDEADBEEF);
    check("rd_addr", {25'h0, rd_addr}, 32'h05);
    check("rd_req_cycles", re_cycles - r0, 3);
    check("rd_req_lat", req_rise_cyc - pop_cyc, 0);
    check("rd_tx_lat", we_rise_cyc - ack_cyc, 1);

    // write
    ack_delay = 2; base = tx_n; w0 = we_cycles;
    send_write(7'h05, 32'h12345678);
    wait_tx(base + 1, 100);
    check("wr_resp", tx_at(base), 32'h06);
    check("wr_addr", {25'h0, wr_addr}, 32'h05);
    check("wr_data", wr_data, 32'h12345678);
    check("wr_req_cycles", we_cycles - w0, 2);

    // leading garbage is dropped silently
    e0 = err_cnt; base = tx_n; reg_rdata = 32'h0BADF00D; ack_delay = 1;
    push(8'h55); push(8'hAA); send_read(7'h02);
    wait_tx(base + RD_LEN, 100);
    check_read("gb", base, 32'h0BADF00D);
    check("gb_addr", {25'h0, rd_addr}, 32'h02);
    check("gb_err", err_cnt - e0, 0);

    // header then silence
    e0 = err_cnt; base = tx_n;
    push(8'h01);
    for (int k = 0; k < 100 && err_cnt == e0; k++) @(negedge clk);
    check("rxto_err", err_cnt - e0, 1);
    check("rxto_cycle", err_cyc - pop_cyc, 15);
    repeat (5) @(negedge clk);
    check("rxto_no_tx", tx_n - base, 0);
    reg_rdata = 32'h89ABCDEF; ack_delay = 2; base = tx_n;
    send_read(7'h03);
    wait_tx(base + RD_LEN, 100);
    check_read("after_to", base, 32'h89ABCDEF);

    // access never acknowledged
    ack_delay = 1000; e0 = err_cnt; base = tx_n; r0 = re_cycles;
    send_read(7'h07);
    wait_tx(base + 1, 100);
    check("acto_resp", tx_at(base), 32'h15);
    check("acto_req_cycles", re_cycles - r0, 15);
    check("acto_err", err_cnt - e0, 1);
    repeat (3) @(negedge clk);
    check("acto_len", tx_n - base, 1);

    // TX backpressure mid-response
    ack_delay = 1; reg_rdata = 32'h11223344; base = tx_n;
    send_read(7'h09);
    wait_tx(base + 1, 100);
    tx_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_stalled", tx_n - base, 1);
    tx_ready = 1'b1;
    wait_tx(base + RD_LEN, 100);
    check_read("bp", base, 32'h11223344);
    check("bp_viol", we_viol, 0);

    // reset in the middle of a write payload
    base = tx_n;
    push(8'h01); push(8'h85); push(8'h78);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_ctl", {12'h0, re, we, dsend, reg_addr, reg_we, reg_re, frame_err}, 32'h0);
    check("rstmid_wdata", reg_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_delay = 2; reg_rdata = 32'hCAFEF00D;
    send_read(7'h05);
    wait_tx(base + RD_LEN, 100);
    check_read("rstmid", base, 32'hCAFEF00D);
    check("rstmid_addr", {25'h0, rd_addr}, 32'h05);

`ifdef DBG_PARSER_CHECKSUM_EN
    // corrupted checksum: no write, error pulse, NAK
    e0 = err_cnt; base = tx_n; w0 = we_cycles;
    push(8'h01); push(8'h85); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    push(8'h8D ^ 8'h01);
    wait_tx(base + 1, 100);
    check("cs_resp", tx_at(base), 32'h15);
    check("cs_no_we", we_cycles - w0, 0);
    check("cs_err", err_cnt - e0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
